execute_stage: RTL and testbench
================================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameter DATA_W, default 32, operand and result width; only 32 is supported.
REQ-002 clk  in  1  system clock; all state changes on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 in_valid  in  1  the decode stage presents a valid operation.
REQ-005 in_ready  out  1  the stage accepts an operation this cycle.
REQ-006 ALU_op  in  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 MUL, 101 DIV, 110 SHIFT, 111 reserved.
REQ-007 signed_mul, left_shift, arith_shift  in  1 each  modifiers for MUL and SHIFT.
REQ-008 mem_write, mem_read, reg_write, mem_access_signed  in  1 each  control passthrough.
REQ-009 mem_access_size  in  2  passthrough size code: 00 byte, 01 half, 10 word, 11 double.
REQ-010 src_a, src_b, src_c  in  32 each  operands from decode.
REQ-011 rd  in  5  destination register.
REQ-012 out_valid  out  1  the output register holds a completed operation.
REQ-013 out_ready  in  1  the memory stage consumes the output this cycle.
REQ-014 result  out  32  ALU result, or the effective address for memory ops.
REQ-015 y_out  out  32  high word of the MUL product; 0 for all other ops.
REQ-016 store_data  out  32  store value (latched src_a).
REQ-017 rd_out, *_out  out  match inputs  registered copies of rd and all control inputs.
REQ-018 div_zero  out  1  the completed DIV had a zero divisor.

Function
REQ-019 Acceptance SHALL occur on a cycle with in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-020 If mem_read or mem_write is set, result SHALL be the effective address, independent of ALU_op.
- mem_write=1: src_b+src_c.
- otherwise: src_a+src_b.
- Addition is modulo 2^32.
REQ-021 AND, OR, ADD and SUB SHALL be 32-bit with wrap-around; SUB is src_a-src_b.
REQ-022 MUL SHALL form a 64-bit product of src_a and src_b.
- Signed two's complement if signed_mul=1, unsigned otherwise.
- Low 32 bits to result, high 32 bits to y_out.
REQ-023 SHIFT SHALL shift src_a by src_b[4:0].
- left_shift=1: logical left.
- left_shift=0, arith_shift=0: logical right.
- left_shift=0, arith_shift=1: arithmetic right.
REQ-024 ALU_op 111 SHALL produce result=0 and pass the control signals through.
REQ-025 Non-DIV ops SHALL have latency 1: out_valid and outputs are updated on the edge that accepts the op.
REQ-026 DIV SHALL be unsigned 32/32 restoring division of src_a by src_b.
- result = quotient; remainder is discarded.
- State machine IDLE -> DIV (32 iterations, 5-bit counter 31..0) -> IDLE.
- Outputs load on the edge that ends the last iteration, 33 cycles after acceptance.
REQ-027 DIV with src_b=0 SHALL skip the iterations.
- Latency 1.
- result=32'hFFFFFFFF, div_zero=1.
REQ-028 div_zero SHALL be 0 for every other completed op.
REQ-029 The output register SHALL hold its value while out_valid && !out_ready.
REQ-030 When out_ready and a new acceptance occur in the same cycle, the output register SHALL load the new op with no bubble.
REQ-031 out_valid SHALL clear on the edge where out_ready=1 and nothing new completes.
REQ-032 in_ready SHALL be 0 for the whole DIV state.
REQ-033 A DIV completing while the prior output is unconsumed SHALL wait in DIV with the counter at 0 until out_ready.

Reset
REQ-034 On rst all of the following SHALL clear to 0: out_valid, result, y_out, store_data, rd_out, all *_out, div_zero, the counter and the divider registers; the state SHALL go to IDLE.
REQ-035 rst asserted during DIV SHALL abandon the division; after release no output for it appears.
REQ-036 in_ready SHALL be 1 on the first cycle after rst deasserts.

Structure
REQ-037 The ALU_op codes, mem_access_size codes and the IDLE/DIV state encoding SHALL live in the shared package sparc_pkg.
REQ-038 The iterative divider SHALL be a sub-module serial_divider.
- Signals: start, dividend, divisor, busy, done, quotient.
- Also clocked by clk/rst.
REQ-039 The combinational ALU, address adder and output register SHALL reside in execute_stage.

Verification
REQ-040 ADD: src_a=32'hFFFFFFFF, src_b=1 -> next edge result=0, out_valid=1, y_out=0.
REQ-041 MUL: signed_mul=1, src_a=-2, src_b=3 -> result=32'hFFFFFFFA, y_out=32'hFFFFFFFF. MUL: signed_mul=0, same operands -> y_out=2.
REQ-042 DIV: src_a=100, src_b=7 -> in_ready=0 for 32 cycles, result=14 at cycle 33. DIV: src_b=0 -> result=32'hFFFFFFFF, div_zero=1 after 1 cycle.
REQ-043 Store: mem_write=1, src_a=32'hAB, src_b=32'h1000, src_c=4 -> result=32'h1004, store_data=32'hAB, mem_write_out=1. SHIFT: arith_shift=1, src_a=32'h80000000, src_b=4 -> result=32'hF8000000.
REQ-044 Back-pressure: out_ready=0 for 5 cycles after an ADD -> output is stable and in_ready=0; then out_ready=1 with a waiting SUB 5-3 -> result=2 on the next edge with no bubble.
REQ-045 rst asserted at DIV iteration 10 -> out_valid=0 and in_ready=1 after release; the following AND 32'hF0 & 32'h3C -> result=32'h30.

Source files
------------

// File: rtl/sparc_pkg.sv
// Shared types for the execute stage: ALU opcodes, memory size codes,
// the execute FSM encoding and the bundles moved through the output register.
package sparc_pkg;

    typedef enum logic [2:0] {
        ALU_AND   = 3'b000,
        ALU_OR    = 3'b001,
        ALU_ADD   = 3'b010,
        ALU_SUB   = 3'b011,
        ALU_MUL   = 3'b100,
        ALU_DIV   = 3'b101,
        ALU_SHIFT = 3'b110,
        ALU_RSVD  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        SIZE_BYTE   = 2'b00,
        SIZE_HALF   = 2'b01,
        SIZE_WORD   = 2'b10,
        SIZE_DOUBLE = 2'b11
    } mem_size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } ex_state_e;

    typedef struct packed {
        logic        mem_write;
        logic        mem_read;
        logic        reg_write;
        logic        mem_access_signed;
        logic [1:0]  mem_access_size;
        logic [4:0]  rd;
        logic [31:0] store_data;
    } ex_ctrl_t;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] y;
        logic        div_zero;
        ex_ctrl_t    ctrl;
    } ex_out_t;

endpackage

// File: rtl/serial_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// done stays high (counter parked at 0) until the next start.
module serial_divider #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient
);

    localparam int CW = $clog2(W);

    logic [W-1:0]  rem_q;
    logic [W-1:0]  quo_q;
    logic [W-1:0]  div_q;
    logic [CW-1:0] cnt_q;
    logic [W:0]    shifted;
    logic [W:0]    diff;

    assign shifted  = {rem_q, quo_q[W-1]};
    assign diff     = shifted - {1'b0, div_q};
    assign quotient = quo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
            cnt_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            div_q <= divisor;
            cnt_q <= CW'(W - 1);
            busy  <= 1'b1;
            done  <= 1'b0;
        end else if (busy) begin
            // a borrow means the trial subtraction failed: restore
            if (diff[W]) begin
                rem_q <= shifted[W-1:0];
                quo_q <= {quo_q[W-2:0], 1'b0};
            end else begin
                rem_q <= diff[W-1:0];
                quo_q <= {quo_q[W-2:0], 1'b1};
            end
            if (cnt_q == '0) begin
                busy <= 1'b0;
                done <= 1'b1;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU and address adder, iterative divide,
// and a valid/ready output register towards the memory stage.
module execute_stage
    import sparc_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        ALU_op,
    input  logic              signed_mul,
    input  logic              left_shift,
    input  logic              arith_shift,
    input  logic              mem_write,
    input  logic              mem_read,
    input  logic              reg_write,
    input  logic              mem_access_signed,
    input  logic [1:0]        mem_access_size,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic [DATA_W-1:0] src_c,
    input  logic [4:0]        rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] y_out,
    output logic [DATA_W-1:0] store_data,
    output logic [4:0]        rd_out,
    output logic              mem_write_out,
    output logic              mem_read_out,
    output logic              reg_write_out,
    output logic              mem_access_signed_out,
    output logic [1:0]        mem_access_size_out,
    output logic              div_zero
);

    ex_state_e         state_q, state_d;
    ex_ctrl_t          ctrl_in, pend_q;
    ex_out_t           new_out, out_q;
    logic              mem_op, free, accept;
    logic              div_iter, div_start, div_fin;
    logic              div_busy, div_done;
    logic [DATA_W-1:0] div_quo;
    logic [DATA_W-1:0] alu_res, alu_y;
    logic              alu_dz;
    logic [2*DATA_W-1:0] ext_a, ext_b, prod;

    assign mem_op    = mem_read | mem_write;
    assign free      = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign div_iter  = (ALU_op == ALU_DIV) && !mem_op && (src_b != '0);
    assign div_start = accept && div_iter;
    assign div_fin   = (state_q == ST_DIV) && div_done && !div_busy && free;

    // sign- or zero-extend to 64 bits; the low 64 bits of the product are exact
    assign ext_a = {{DATA_W{signed_mul & src_a[DATA_W-1]}}, src_a};
    assign ext_b = {{DATA_W{signed_mul & src_b[DATA_W-1]}}, src_b};
    assign prod  = ext_a * ext_b;

    always_comb begin
        alu_res = '0;
        alu_y   = '0;
        alu_dz  = 1'b0;
        if (mem_op) begin
            alu_res = mem_write ? src_b + src_c : src_a + src_b;
        end else begin
            unique case (alu_op_e'(ALU_op))
                ALU_AND: alu_res = src_a & src_b;
                ALU_OR:  alu_res = src_a | src_b;
                ALU_ADD: alu_res = src_a + src_b;
                ALU_SUB: alu_res = src_a - src_b;
                ALU_MUL: begin
                    alu_res = prod[DATA_W-1:0];
                    alu_y   = prod[2*DATA_W-1:DATA_W];
                end
                ALU_DIV: begin
                    alu_res = '1;
                    alu_dz  = (src_b == '0);
                end
                ALU_SHIFT: begin
                    if (left_shift)
                        alu_res = src_a << src_b[4:0];
                    else if (arith_shift)
                        alu_res = $unsigned($signed(src_a) >>> src_b[4:0]);
                    else
                        alu_res = src_a >> src_b[4:0];
                end
                ALU_RSVD: alu_res = '0;
            endcase
        end
    end

    assign ctrl_in = '{
        mem_write:         mem_write,
        mem_read:          mem_read,
        reg_write:         reg_write,
        mem_access_signed: mem_access_signed,
        mem_access_size:   mem_access_size,
        rd:                rd,
        store_data:        src_a
    };

    assign new_out = '{
        result:   alu_res,
        y:        alu_y,
        div_zero: alu_dz,
        ctrl:     ctrl_in
    };

    serial_divider #(.W(DATA_W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (src_a),
        .divisor  (src_b),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (div_start) state_d = ST_DIV;
            ST_DIV:  if (div_fin)   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == ST_IDLE) && free;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q     <= '0;
            pend_q    <= '0;
            out_valid <= 1'b0;
        end else begin
            if (div_start)
                pend_q <= ctrl_in;
            if (accept && !div_iter) begin
                out_q     <= new_out;
                out_valid <= 1'b1;
            end else if (div_fin) begin
                out_q     <= '{result: div_quo, y: '0, div_zero: 1'b0, ctrl: pend_q};
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign result                = out_q.result;
    assign y_out                 = out_q.y;
    assign div_zero              = out_q.div_zero;
    assign store_data            = out_q.ctrl.store_data;
    assign rd_out                = out_q.ctrl.rd;
    assign mem_write_out         = out_q.ctrl.mem_write;
    assign mem_read_out          = out_q.ctrl.mem_read;
    assign reg_write_out         = out_q.ctrl.reg_write;
    assign mem_access_signed_out = out_q.ctrl.mem_access_signed;
    assign mem_access_size_out   = out_q.ctrl.mem_access_size;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed operations, an arithmetic reference
// model with a per-cycle compare, and literal checks on known results.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [2:0]  ALU_op;
    logic        signed_mul, left_shift, arith_shift;
    logic        mem_write, mem_read, reg_write, mem_access_signed;
    logic [1:0]  mem_access_size;
    logic [31:0] src_a, src_b, src_c;
    logic [4:0]  rd;
    logic        out_valid, out_ready;
    logic [31:0] result, y_out, store_data;
    logic [4:0]  rd_out;
    logic        mem_write_out, mem_read_out, reg_write_out;
    logic        mem_access_signed_out, div_zero;
    logic [1:0]  mem_access_size_out;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    execute_stage #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALU_op(ALU_op), .signed_mul(signed_mul),
        .left_shift(left_shift), .arith_shift(arith_shift),
        .mem_write(mem_write), .mem_read(mem_read),
        .reg_write(reg_write), .mem_access_signed(mem_access_signed),
        .mem_access_size(mem_access_size),
        .src_a(src_a), .src_b(src_b), .src_c(src_c), .rd(rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .y_out(y_out), .store_data(store_data),
        .rd_out(rd_out), .mem_write_out(mem_write_out),
        .mem_read_out(mem_read_out), .reg_write_out(reg_write_out),
        .mem_access_signed_out(mem_access_signed_out),
        .mem_access_size_out(mem_access_size_out),
        .div_zero(div_zero)
    );

    typedef struct {
        logic [31:0] res, y, sd;
        logic [4:0]  rd;
        logic        mw, mr, rw, mas, dz;
        logic [1:0]  sz;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // What the op on the current inputs must produce, from plain arithmetic
    function automatic exp_t model_op();
        exp_t e;
        longint          sa, sb;
        longint unsigned ua, ub, p;
        int              sh;
        e = '{res: 32'd0, y: 32'd0, sd: src_a, rd: rd, mw: mem_write, mr: mem_read,
              rw: reg_write, mas: mem_access_signed, dz: 1'b0, sz: mem_access_size};
        sh = int'(src_b[4:0]);
        if (mem_write) e.res = src_b + src_c;
        else if (mem_read) e.res = src_a + src_b;
        else case (ALU_op)
            3'd0: e.res = src_a & src_b;
            3'd1: e.res = src_a | src_b;
            3'd2: e.res = src_a + src_b;
            3'd3: e.res = src_a - src_b;
            3'd4: begin
                if (signed_mul) begin
                    sa = $signed(src_a);
                    sb = $signed(src_b);
                    p = longint'(sa * sb);
                end else begin
                    ua = src_a;
                    ub = src_b;
                    p = ua * ub;
                end
                e.res = p[31:0];
                e.y = p[63:32];
            end
            3'd5: begin
                if (src_b == 0) begin
                    e.res = 32'hFFFF_FFFF;
                    e.dz = 1'b1;
                end else e.res = src_a / src_b;
            end
            3'd6: begin
                if (left_shift) e.res = src_a << sh;
                else if (arith_shift) e.res = 32'($signed(src_a) >>> sh);
                else e.res = src_a >> sh;
            end
            default: e.res = 32'd0;
        endcase
        return e;
    endfunction

    logic m_valid, m_div_on;
    int   m_div_cyc;
    exp_t m_e, m_div_e;

    always @(posedge clk or posedge rst) begin
        exp_t ne, e;
        logic fr, ld;
        if (rst) begin
            m_valid   <= 1'b0;
            m_div_on  <= 1'b0;
            m_div_cyc <= 0;
            m_e       <= '{default: 0};
        end else begin
            fr = !m_valid || out_ready;
            ld = 1'b0;
            ne = m_e;
            if (in_valid && !m_div_on && fr) begin
                e = model_op();
                if (ALU_op == 3'd5 && !mem_write && !mem_read && src_b != 0) begin
                    m_div_on  <= 1'b1;
                    m_div_cyc <= 0;
                    m_div_e   <= e;
                end else begin
                    ld = 1'b1;
                    ne = e;
                end
            end else if (m_div_on) begin
                if (m_div_cyc + 1 >= 33 && fr) begin
                    ld = 1'b1;
                    ne = m_div_e;
                    m_div_on <= 1'b0;
                end
                m_div_cyc <= m_div_cyc + 1;
            end
            if (ld) begin
                m_valid <= 1'b1;
                m_e     <= ne;
            end else if (out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_in_ready", in_ready, 32'(!m_div_on && (!m_valid || out_ready)));
            chk("m_out_valid", out_valid, 32'(m_valid));
            if (m_valid) begin
                chk("m_result", result, m_e.res);
                chk("m_y_out", y_out, m_e.y);
                chk("m_store_data", store_data, m_e.sd);
                chk("m_rd_out", rd_out, 32'(m_e.rd));
                chk("m_ctrl", {27'd0, mem_write_out, mem_read_out, reg_write_out,
                    mem_access_signed_out, div_zero},
                    {27'd0, m_e.mw, m_e.mr, m_e.rw, m_e.mas, m_e.dz});
                chk("m_size", 32'(mem_access_size_out), 32'(m_e.sz));
            end
        end
    end

    task automatic set_op(input logic [2:0] op, input logic [31:0] a, b, c);
        ALU_op = op;
        src_a = a;
        src_b = b;
        src_c = c;
        rd = 5'($urandom_range(0, 31));
        signed_mul = 0; left_shift = 0; arith_shift = 0;
        mem_write = 0; mem_read = 0; reg_write = 1; mem_access_signed = 0;
        mem_access_size = 2'b10;
    endtask

    // Present the op and return 2 time units after the edge that accepts it
    task automatic send();
        logic ok = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!m_div_on && (!m_valid || out_ready)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL send_timeout: got no acceptance, required one within 100 cycles");
        end
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required end before 100us");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        set_op(3'd0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_rd_out", rd_out, 0);
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);

        set_op(3'd2, 32'hFFFF_FFFF, 1, 0); send();
        chk("add_res", result, 0);
        chk("add_valid", out_valid, 1);
        chk("add_y", y_out, 0);

        set_op(3'd4, 32'hFFFF_FFFE, 3, 0); signed_mul = 1; send();
        chk("muls_res", result, 32'hFFFF_FFFA);
        chk("muls_y", y_out, 32'hFFFF_FFFF);
        set_op(3'd4, 32'hFFFF_FFFE, 3, 0); send();
        chk("mulu_y", y_out, 2);

        set_op(3'd5, 100, 7, 0); send();
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #2;
            chk("div_busy_ready", in_ready, 0);
        end
        @(posedge clk); #2;
        chk("div_res", result, 14);
        chk("div_valid", out_valid, 1);

        set_op(3'd5, 55, 0, 0); send();
        chk("div0_res", result, 32'hFFFF_FFFF);
        chk("div0_flag", div_zero, 1);

        set_op(3'd5, 7, 100, 0); send();
        repeat (34) @(posedge clk);
        #2;

        set_op(3'd0, 32'hAB, 32'h1000, 4); mem_write = 1; reg_write = 0; send();
        chk("st_addr", result, 32'h1004);
        chk("st_data", store_data, 32'hAB);
        chk("st_mw", mem_write_out, 1);

        set_op(3'd3, 32'h10, 32'h20, 9); mem_read = 1; mem_access_size = 2'b01;
        mem_access_signed = 1; send();
        chk("ld_addr", result, 32'h30);

        set_op(3'd6, 32'h8000_0000, 4, 0); arith_shift = 1; send();
        chk("sra_res", result, 32'hF800_0000);
        set_op(3'd6, 32'h8000_0000, 36, 0); send();
        set_op(3'd6, 32'h0000_0003, 31, 0); left_shift = 1; send();
        set_op(3'd1, 32'hF0F0_0000, 32'h0000_0F0F, 0); send();
        set_op(3'd7, 32'h1234, 32'h5678, 0); send();
        chk("rsvd_res", result, 0);

        set_op(3'd2, 2, 3, 0); send();
        out_ready = 1'b0;
        set_op(3'd3, 5, 3, 0);
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #2;
            chk("bp_hold", result, 5);
            chk("bp_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        chk("bp_sub", result, 2);
        chk("bp_valid", out_valid, 1);

        set_op(3'd5, 100, 7, 0); send();
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        chk("rdiv_valid", out_valid, 0);
        chk("rdiv_ready", in_ready, 1);
        repeat (40) @(posedge clk);
        #2;
        chk("rdiv_none", out_valid, 0);
        set_op(3'd0, 32'hF0, 32'h3C, 0); send();
        chk("and_res", result, 32'h30);

        repeat (3) @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
